// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: inverse S-box, GF(2^8) arithmetic and the
// inverse row/column transforms on a 128-bit column-major state.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte (r,c) sits at index 4c+r, byte 0 in the top bits; row r rotates right by r.
  function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [AES_STATE_W-1:0] inv_sub_bytes(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [AES_STATE_W-1:0] inv_mix_columns(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_pipe_stage_reg.sv
// One valid/ready register slice; ready toward the source is combinational
// from the sink, so a chain of slices forms a bubble-free pipeline.
module aes_pipe_stage_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic load;

  assign load     = !out_valid || out_ready;
  assign in_ready = load && !flush && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
    end
  end

  // Flush leaves the payload untouched; only accepted beats overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (in_valid && in_ready) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/aes_inv_round_pipe.sv
// Flow-controlled AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey,
// optional InvMixColumns) with 1..3 register stages and a tag sideband.
module aes_inv_round_pipe
  import aes_pkg::*;
#(
  parameter int STAGES   = 2,
  parameter int TAG_W    = 4,
  parameter int PROBE_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_state,
  input  logic [127:0]     s_key,
  input  logic             s_last,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_state,
  output logic             m_last,
  output logic [TAG_W-1:0] m_tag,
  output logic [127:0]     m_probe_isb,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  localparam int SW  = AES_STATE_W;
  localparam int PBW = (PROBE_EN != 0) ? SW : 0;
  localparam int KW  = 2 * SW + 1 + TAG_W;
  localparam int BW  = SW + 1 + TAG_W + PBW;
  localparam int OW  = SW + 1 + TAG_W + PBW;

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("aes_inv_round_pipe: STAGES must be in 1..3");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $error("aes_inv_round_pipe: TAG_W must be in 1..16");
  end

  logic [SW-1:0]    isb_in;
  logic             fin_valid, fin_ready, fin_last;
  logic [SW-1:0]    fin_state, fin_probe;
  logic [TAG_W-1:0] fin_tag;
  logic [OW-1:0]    out_d, out_q;
  logic             out_v;
  logic [2:0]       vq;

  // Input side: InvShiftRows and InvSubBytes straight off the source.
  assign isb_in = inv_sub_bytes(inv_shift_rows(s_state));

  if (STAGES == 1) begin : g_s1
    logic [SW-1:0] ark;
    assign ark       = isb_in ^ s_key;
    assign fin_valid = s_valid;
    assign s_ready   = fin_ready;
    assign fin_state = s_last ? ark : inv_mix_columns(ark);
    assign fin_last  = s_last;
    assign fin_tag   = s_tag;
    assign fin_probe = isb_in;
    assign vq        = {2'b00, out_v};
  end else if (STAGES == 2) begin : g_s2
    logic [KW-1:0]    a_q;
    logic             a_v;
    logic [SW-1:0]    a_isb, a_key, ark;
    logic             a_last;
    logic [TAG_W-1:0] a_tag;

    aes_pipe_stage_reg #(.DATA_W(KW)) u_stage0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(s_valid), .in_ready(s_ready), .in_data({isb_in, s_key, s_last, s_tag}),
      .out_valid(a_v), .out_ready(fin_ready), .out_data(a_q)
    );

    // Stage 0 -> output: AddRoundKey and the last-round mux.
    assign a_isb     = a_q[KW-1 -: SW];
    assign a_key     = a_q[KW-SW-1 -: SW];
    assign a_last    = a_q[TAG_W];
    assign a_tag     = a_q[TAG_W-1:0];
    assign ark       = a_isb ^ a_key;
    assign fin_valid = a_v;
    assign fin_state = a_last ? ark : inv_mix_columns(ark);
    assign fin_last  = a_last;
    assign fin_tag   = a_tag;
    assign fin_probe = a_isb;
    assign vq        = {1'b0, a_v, out_v};
  end else if (STAGES == 3) begin : g_s3
    logic [KW-1:0]    a_q;
    logic             a_v, b_v, b_ready;
    logic [SW-1:0]    a_isb, a_key, ark;
    logic             a_last;
    logic [TAG_W-1:0] a_tag;
    logic [BW-1:0]    b_d, b_q;
    logic [SW-1:0]    b_ark;
    logic             b_last;
    logic [TAG_W-1:0] b_tag;

    aes_pipe_stage_reg #(.DATA_W(KW)) u_stage0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(s_valid), .in_ready(s_ready), .in_data({isb_in, s_key, s_last, s_tag}),
      .out_valid(a_v), .out_ready(b_ready), .out_data(a_q)
    );

    // Stage 0 -> stage 1: AddRoundKey.
    assign a_isb  = a_q[KW-1 -: SW];
    assign a_key  = a_q[KW-SW-1 -: SW];
    assign a_last = a_q[TAG_W];
    assign a_tag  = a_q[TAG_W-1:0];
    assign ark    = a_isb ^ a_key;

    if (PROBE_EN != 0) begin : g_b_probe
      assign b_d       = {ark, a_last, a_tag, a_isb};
      assign fin_probe = b_q[SW-1:0];
    end else begin : g_b_noprobe
      assign b_d       = {ark, a_last, a_tag};
      assign fin_probe = '0;
    end

    aes_pipe_stage_reg #(.DATA_W(BW)) u_stage1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(a_v), .in_ready(b_ready), .in_data(b_d),
      .out_valid(b_v), .out_ready(fin_ready), .out_data(b_q)
    );

    // Stage 1 -> output: InvMixColumns and the last-round mux.
    assign b_ark     = b_q[BW-1 -: SW];
    assign b_last    = b_q[BW-SW-1];
    assign b_tag     = b_q[BW-SW-2 -: TAG_W];
    assign fin_valid = b_v;
    assign fin_state = b_last ? b_ark : inv_mix_columns(b_ark);
    assign fin_last  = b_last;
    assign fin_tag   = b_tag;
    assign vq        = {a_v, b_v, out_v};
  end

  if (PROBE_EN != 0) begin : g_out_probe
    assign out_d       = {fin_state, fin_last, fin_tag, fin_probe};
    assign m_probe_isb = out_q[SW-1:0];
  end else begin : g_out_noprobe
    assign out_d       = {fin_state, fin_last, fin_tag};
    assign m_probe_isb = '0;
  end

  // Output register stage.
  aes_pipe_stage_reg #(.DATA_W(OW)) u_stage_out (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(fin_valid), .in_ready(fin_ready), .in_data(out_d),
    .out_valid(out_v), .out_ready(m_ready), .out_data(out_q)
  );

  assign m_valid   = out_v;
  assign m_state   = out_q[OW-1 -: SW];
  assign m_last    = out_q[OW-SW-1];
  assign m_tag     = out_q[OW-SW-2 -: TAG_W];
  assign occupancy = {1'b0, vq[0]} + {1'b0, vq[1]} + {1'b0, vq[2]};

endmodule

// File: tb/tb_aes_inv_round_pipe.sv
// Bench for aes_inv_round_pipe: one instance per depth (STAGES = 1, 2, 3),
// known-answer vectors, streaming against a byte-level AES reference model.
module tb_aes_inv_round_pipe;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             s_valid[3], s_ready[3], s_last[3], m_valid[3], m_ready[3], m_last[3], flush[3];
  logic [127:0]     s_state[3], s_key[3], m_state[3], m_probe_isb[3];
  logic [TAG_W-1:0] s_tag[3], m_tag[3];
  logic [1:0]       occupancy[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_round_pipe #(.STAGES(g + 1), .TAG_W(TAG_W), .PROBE_EN(1)) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_state(s_state[g]), .s_key(s_key[g]),
      .s_last(s_last[g]), .s_tag(s_tag[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_state(m_state[g]), .m_last(m_last[g]),
      .m_tag(m_tag[g]), .m_probe_isb(m_probe_isb[g]),
      .flush(flush[g]), .occupancy(occupancy[g])
    );
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Reference model: inverse S-box derived from the field inverse and the affine map.
  logic [7:0] isbox [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_isb(input logic [127:0] s);
    logic [7:0] st[4][4];
    logic [7:0] o[4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) st[w][c] = s[127-8*(4*c+w) -: 8];
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) o[w][(c+w)%4] = isbox[st[w][c]];
    for (int c = 0; c < 4; c++) for (int w = 0; w < 4; w++) r[127-8*(4*c+w) -: 8] = o[w][c];
    return r;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] x, r;
    logic [7:0] coef[4];
    logic [7:0] a[4];
    logic [7:0] acc;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    x = ref_isb(s) ^ k;
    if (last) return x;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = x[127-8*(4*c+j) -: 8];
      for (int w = 0; w < 4; w++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j-w+4)%4], a[j]);
        r[127-8*(4*c+w) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    int           d;
    logic [127:0] st;
    logic [127:0] key;
    logic         last;
    logic [3:0]   tag;
    logic [127:0] exp_st;
    logic [127:0] exp_pb;
  } vec_t;

  typedef struct {
    logic [127:0] st;
    logic [127:0] pb;
    logic         last;
    logic [3:0]   tag;
  } beat_t;

  vec_t vt[6];

  task automatic run_single(input vec_t v);
    int d, k;
    d = v.d;
    @(negedge clk);
    s_state[d] = v.st; s_key[d] = v.key; s_last[d] = v.last; s_tag[d] = v.tag;
    s_valid[d] = 1'b1; m_ready[d] = 1'b1;
    #1 chk($sformatf("kat_ready_d%0d", d), s_ready[d], 1);
    @(negedge clk);
    s_valid[d] = 1'b0;
    k = 1;
    while (!m_valid[d] && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk($sformatf("kat_latency_d%0d", d), k, d + 1);
    chk($sformatf("kat_state_d%0d", d), m_state[d], v.exp_st);
    chk($sformatf("kat_probe_d%0d", d), m_probe_isb[d], v.exp_pb);
    chk($sformatf("kat_tag_d%0d", d), m_tag[d], v.tag);
    chk($sformatf("kat_last_d%0d", d), m_last[d], v.last);
    @(negedge clk);
  endtask

  task automatic stream(input int d, input int n, input bit rnd);
    beat_t q[$];
    beat_t e, nb;
    int sent, got, cyc;
    bit stall;
    logic [127:0] h_st, h_pb, b_st, b_key;
    logic [3:0] h_tag;
    logic h_last, b_last;
    sent = 0; got = 0; cyc = 0; stall = 0;
    h_st = '0; h_pb = '0; h_tag = '0; h_last = 1'b0;
    b_st = rand128(); b_key = rand128(); b_last = 1'($urandom_range(0, 1));
    while (got < n && cyc < n * 4 + 20) begin
      @(negedge clk);
      s_valid[d] = (sent < n);
      s_state[d] = b_st; s_key[d] = b_key; s_last[d] = b_last; s_tag[d] = sent[3:0];
      m_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        chk("hold_valid", m_valid[d], 1);
        chk("hold_state", m_state[d], h_st);
        chk("hold_probe", m_probe_isb[d], h_pb);
        chk("hold_tag", m_tag[d], h_tag);
        chk("hold_last", m_last[d], h_last);
      end
      if (!rnd) begin
        if (cyc >= d + 1 && cyc <= n) chk($sformatf("b2b_occ_d%0d", d), occupancy[d], d + 1);
        if (cyc >= d + 1 && cyc < n + d + 1) chk($sformatf("b2b_valid_d%0d", d), m_valid[d], 1);
      end
      if (m_valid[d] && m_ready[d]) begin
        if (q.size() == 0) begin
          chk($sformatf("spurious_out_d%0d", d), m_valid[d], 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream_state_d%0d", d), m_state[d], e.st);
          chk($sformatf("stream_probe_d%0d", d), m_probe_isb[d], e.pb);
          chk($sformatf("stream_last_d%0d", d), m_last[d], e.last);
          chk($sformatf("stream_tag_d%0d", d), m_tag[d], e.tag);
          got++;
        end
      end
      stall  = m_valid[d] && !m_ready[d];
      h_st   = m_state[d]; h_pb = m_probe_isb[d]; h_tag = m_tag[d]; h_last = m_last[d];
      if (s_valid[d] && s_ready[d]) begin
        nb.st = ref_round(b_st, b_key, b_last);
        nb.pb = ref_isb(b_st);
        nb.last = b_last;
        nb.tag = sent[3:0];
        q.push_back(nb);
        sent++;
        b_st = rand128(); b_key = rand128(); b_last = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    s_valid[d] = 1'b0;
    chk($sformatf("stream_count_d%0d", d), got, n);
    chk($sformatf("stream_pending_d%0d", d), q.size(), 0);
    @(negedge clk);
    #1 chk($sformatf("stream_drained_d%0d", d), m_valid[d], 0);
  endtask

  task automatic present(input int d, input logic [127:0] st, input logic [127:0] key,
                         input logic last, input logic [3:0] tag);
    s_state[d] = st; s_key[d] = key; s_last[d] = last; s_tag[d] = tag; s_valid[d] = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] a_st, a_key, c_st, c_key, tmp;
    int k;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      s_valid[d] = 1'b0; s_state[d] = '0; s_key[d] = '0; s_last[d] = 1'b0; s_tag[d] = '0;
      m_ready[d] = 1'b0; flush[d] = 1'b0;
    end
    build_sbox();

    vt[0] = '{1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h0, 1'b1, 4'd5,
              128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
    vt[1] = '{0, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h0, 1'b1, 4'd5,
              128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
    vt[2] = '{2, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h0, 1'b1, 4'd5,
              128'hbd6e7c3df2b5779e0b61216e8b10b689, 128'hbd6e7c3df2b5779e0b61216e8b10b689};
    vt[3] = '{2, {16{8'h63}}, {4{32'h046681e5}}, 1'b0, 4'd3, {4{32'hd4bf5d30}}, 128'h0};
    vt[4] = '{2, {16{8'h63}}, {4{32'h046681e5}}, 1'b1, 4'd9, {4{32'h046681e5}}, 128'h0};
    vt[5] = '{0, {16{8'h63}}, {4{32'h046681e5}}, 1'b0, 4'd12, {4{32'hd4bf5d30}}, 128'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    s_valid[0] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid_d%0d", d), m_valid[d], 0);
      chk($sformatf("rst_occ_d%0d", d), occupancy[d], 0);
      chk($sformatf("rst_ready_d%0d", d), s_ready[d], 0);
      chk($sformatf("rst_state_d%0d", d), m_state[d], 0);
    end
    @(negedge clk);
    s_valid[0] = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_single(vt[i]);

    for (int d = 0; d < 3; d++) stream(d, 16, 1'b0);
    for (int d = 0; d < 3; d++) stream(d, 200, 1'b1);

    // Flush with a full, stalled STAGES=2 pipeline.
    a_st = rand128(); a_key = rand128(); c_st = rand128(); c_key = rand128();
    @(negedge clk);
    m_ready[1] = 1'b0;
    present(1, a_st, a_key, 1'b0, 4'd1);
    #1 chk("flush_fill_a", s_ready[1], 1);
    @(negedge clk);
    present(1, rand128(), rand128(), 1'b1, 4'd2);
    #1 chk("flush_fill_b", s_ready[1], 1);
    @(negedge clk);
    present(1, c_st, c_key, 1'b1, 4'd3);
    #1;
    chk("full_ready", s_ready[1], 0);
    chk("full_occ", occupancy[1], 2);
    chk("full_valid", m_valid[1], 1);
    @(negedge clk);
    flush[1] = 1'b1;
    #1 chk("flush_ready", s_ready[1], 0);
    @(negedge clk);
    flush[1] = 1'b0;
    m_ready[1] = 1'b1;
    #1;
    chk("post_flush_valid", m_valid[1], 0);
    chk("post_flush_occ", occupancy[1], 0);
    chk("post_flush_ready", s_ready[1], 1);
    tmp = ref_round(a_st, a_key, 1'b0);
    chk("post_flush_data_kept", m_state[1], tmp);
    @(negedge clk);
    s_valid[1] = 1'b0;
    k = 1;
    while (!m_valid[1] && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("held_beat_latency", k, 2);
    tmp = ref_round(c_st, c_key, 1'b1);
    chk("held_beat_state", m_state[1], tmp);
    chk("held_beat_tag", m_tag[1], 3);
    @(negedge clk);

    // Reset with two beats in flight in the STAGES=3 pipeline.
    @(negedge clk);
    m_ready[2] = 1'b0;
    present(2, rand128(), rand128(), 1'b0, 4'd7);
    @(negedge clk);
    present(2, rand128(), rand128(), 1'b1, 4'd8);
    @(negedge clk);
    #1 chk("inflight_occ", occupancy[2], 2);
    rst = 1'b1;
    #1;
    chk("midrst_valid", m_valid[2], 0);
    chk("midrst_state", m_state[2], 0);
    chk("midrst_tag", m_tag[2], 0);
    chk("midrst_last", m_last[2], 0);
    chk("midrst_probe", m_probe_isb[2], 0);
    chk("midrst_occ", occupancy[2], 0);
    chk("midrst_ready", s_ready[2], 0);
    @(negedge clk);
    rst = 1'b0;
    s_valid[2] = 1'b0;
    m_ready[2] = 1'b1;
    #1 chk("release_ready", s_ready[2], 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("release_idle_valid", m_valid[2], 0);
    end
    run_single(vt[3]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
